// File: rtl/cs_out_collector.sv
// Output collector for the CS selector: drops the warm-up results, buffers valid
// Y results in a FIFO drained by valid/ready, and keeps a sticky overflow flag.
module cs_out_collector #(
    parameter int DW     = 10,
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int WARMUP = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic [DW-1:0] y_in,
    input  logic          y_en,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW:0]   level,
    output logic [15:0]   count,
    output logic          overflow
);

    localparam int WCW = (WARMUP > 1) ? $clog2(WARMUP) : 1;

    typedef enum logic {WARM, RUN} state_t;

    state_t          state_q, state_d;
    logic [WCW-1:0]  warm_q, warm_d;
    logic [DW-1:0]   mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     level_q, level_d, avail;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic [15:0]     count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            push_req, push, pop, drop;

    always_comb begin
        state_d  = state_q;
        warm_d   = warm_q;
        push_req = 1'b0;
        unique case (state_q)
            WARM: begin
                if (WARMUP == 0) begin
                    state_d  = RUN;
                    push_req = y_en;
                end else if (y_en) begin
                    if (warm_q == WCW'(WARMUP - 1)) begin
                        state_d = RUN;
                        warm_d  = '0;
                    end else begin
                        warm_d = warm_q + WCW'(1);
                    end
                end
            end
            RUN: push_req = y_en;
        endcase
        if (flush) begin
            state_d  = WARM;
            warm_d   = '0;
            push_req = 1'b0;
        end
    end

    always_comb begin
        pop  = out_valid_q && out_ready && !flush;
        push = push_req && ((level_q < (AW+1)'(DEPTH)) || pop);
        drop = push_req && !push;

        wr_ptr_d = wr_ptr_q + (push ? AW'(1) : AW'(0));
        rd_ptr_d = rd_ptr_q + (pop  ? AW'(1) : AW'(0));

        level_d = level_q;
        if (push && !pop)      level_d = level_q + (AW+1)'(1);
        else if (pop && !push) level_d = level_q - (AW+1)'(1);

        // Only words stored before this edge may be presented: no push-to-output bypass.
        avail       = level_q - (pop ? (AW+1)'(1) : (AW+1)'(0));
        out_valid_d = (avail != '0);
        out_data_d  = out_valid_d ? mem_q[rd_ptr_d] : out_data_q;

        count_d = count_q;
        if (push && (count_q != 16'hFFFF)) count_d = count_q + 16'd1;
        overflow_d = overflow_q | drop;

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= WARM;
            warm_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            warm_q      <= warm_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= y_in;
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign level     = level_q;
    assign count     = count_q;
    assign overflow  = overflow_q;

endmodule
